cache_port_arbiter: RTL and testbench

- Shares the single core-side port of the set-associative cache between NUM_REQ requesters, for example the instruction fetch and the LSU.
- Uses the same req/gnt/rvalid protocol on both sides.
- Serialises accesses, because the cache accepts one transaction at a time and gives exactly one rvalid per grant.
- Routes each response back to the requester that owns the transaction.

---
 rtl/cache_arb_pkg.sv | 10 +
 rtl/arb_priority_select.sv | 18 +
 rtl/cache_port_arbiter.sv | 82 ++++++++
 tb/tb_cache_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared state encoding and per-requester field slicing for the cache port arbiter
package cache_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_WAIT, RESP_WAIT} arb_state_e;
  function automatic logic [31:0] slice32(input logic [255:0] v, input logic [2:0] k);
    return v[{k, 5'd0} +: 32];
  endfunction
  function automatic logic [3:0] slice4(input logic [31:0] v, input logic [2:0] k);
    return v[{k, 2'd0} +: 4];
  endfunction
endpackage

// File: rtl/arb_priority_select.sv
// arb_priority_select: picks the first active request at or after the start pointer, wrapping around
module arb_priority_select #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_winner,
  output logic         o_any
);
  // scan from farthest to nearest offset so the nearest active request overwrites the rest
  always_comb begin
    o_winner = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[(int'(i_ptr) + i) % N]) o_winner = W'((int'(i_ptr) + i) % N);
  end
  assign o_any = |i_req;
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: serialises NUM_REQ requesters onto one cache port; CACHE_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]    req_req_i,
  input  logic [NUM_REQ*32-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0] req_wdata_i,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [NUM_REQ*4-1:0]  req_be_i,
  output logic [NUM_REQ-1:0]    req_gnt_o,
  output logic [NUM_REQ-1:0]    req_rvalid_o,
  output logic [31:0]           req_rdata_o,
  output logic [NUM_REQ-1:0]    req_error_o,
  output logic                  cache_req_o,
  output logic [31:0]           cache_addr_o,
  output logic [31:0]           cache_wdata_o,
  output logic                  cache_we_o,
  output logic [3:0]            cache_be_o,
  input  logic                  cache_gnt_i,
  input  logic                  cache_rvalid_i,
  input  logic [31:0]           cache_rdata_i,
  input  logic                  cache_error_i
);
  localparam int IDX_W = $clog2(NUM_REQ);
  arb_state_e       r_state, w_next;
  logic [IDX_W-1:0] r_owner, w_winner, w_ptr;
  logic             w_any, w_gw, w_rw;
  logic [NUM_REQ-1:0] w_onehot;

  arb_priority_select #(.N(NUM_REQ), .W(IDX_W)) u_sel (
    .i_req(req_req_i), .i_ptr(w_ptr), .o_winner(w_winner), .o_any(w_any)
  );

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  // advance the search start past each new winner so requesters take turns
  always_ff @(posedge clk)
    if (reset) r_ptr <= '0;
    else if (r_state == IDLE && w_any) r_ptr <= IDX_W'((int'(w_winner) + 1) % NUM_REQ);
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // one transaction at a time: arbitrate, hold until granted, wait for its single response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_any ? GRANT_WAIT : IDLE;
      GRANT_WAIT: w_next = cache_gnt_i ? RESP_WAIT : GRANT_WAIT;
      RESP_WAIT:  w_next = cache_rvalid_i ? IDLE : RESP_WAIT;
      default:    w_next = IDLE;
    endcase
  end

  // owner is captured only at arbitration and stays fixed for the whole transaction
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) r_owner <= w_winner;
    end

  assign w_gw          = r_state == GRANT_WAIT;
  assign w_rw          = r_state == RESP_WAIT;
  assign w_onehot      = NUM_REQ'(1) << r_owner;
  assign cache_req_o   = w_gw;
  assign cache_addr_o  = w_gw ? slice32(256'(req_addr_i), 3'(r_owner)) : '0;
  assign cache_wdata_o = w_gw ? slice32(256'(req_wdata_i), 3'(r_owner)) : '0;
  assign cache_we_o    = w_gw & req_we_i[r_owner];
  assign cache_be_o    = w_gw ? slice4(32'(req_be_i), 3'(r_owner)) : '0;
  assign req_gnt_o     = (w_gw & cache_gnt_i) ? w_onehot : '0;
  assign req_rvalid_o  = (w_rw & cache_rvalid_i) ? w_onehot : '0;
  assign req_error_o   = (w_rw & cache_rvalid_i & cache_error_i) ? w_onehot : '0;
  assign req_rdata_o   = w_rw ? cache_rdata_i : '0;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed self-checking bench for cache_port_arbiter with NUM_REQ=2
module tb_cache_port_arbiter;
  logic        clk = 0, reset = 0;
  logic [1:0]  req_req_i = 0, req_we_i = 0;
  logic [63:0] req_addr_i = 0, req_wdata_i = 0;
  logic [7:0]  req_be_i = 0;
  logic [1:0]  req_gnt_o, req_rvalid_o, req_error_o;
  logic [31:0] req_rdata_o, cache_addr_o, cache_wdata_o, cache_rdata_i = 0;
  logic        cache_req_o, cache_we_o, cache_gnt_i = 0, cache_rvalid_i = 0, cache_error_i = 0;
  logic [3:0]  cache_be_o;
  int errors = 0, checks = 0;

  cache_port_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .reset(reset), .req_req_i(req_req_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_we_i(req_we_i), .req_be_i(req_be_i),
    .req_gnt_o(req_gnt_o), .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o),
    .req_error_o(req_error_o), .cache_req_o(cache_req_o), .cache_addr_o(cache_addr_o),
    .cache_wdata_o(cache_wdata_o), .cache_we_o(cache_we_o), .cache_be_o(cache_be_o),
    .cache_gnt_i(cache_gnt_i), .cache_rvalid_i(cache_rvalid_i),
    .cache_rdata_i(cache_rdata_i), .cache_error_i(cache_error_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    req_req_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; req_be_i = 0;
    cache_gnt_i = 0; cache_rvalid_i = 0; cache_error_i = 0; cache_rdata_i = 32'h1234_5678;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cache_req_o, cache_we_o, req_gnt_o, req_rvalid_o, req_error_o} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {cache_req_o, cache_we_o, req_gnt_o, req_rvalid_o, req_error_o});
    end
    checks++;
    if ({req_rdata_o, cache_addr_o, cache_wdata_o, cache_be_o} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%h required all 0", req_rdata_o, cache_addr_o, cache_wdata_o, cache_be_o);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req_req_i = 2'b01; req_addr_i[31:0] = 32'h100;
    #1;
    checks++;
    if (cache_req_o !== 1'b0) begin errors++; $display("FAIL single_idle_req: got %b required 0", cache_req_o); end
    step();
    checks++;
    if ({cache_req_o, cache_addr_o, req_gnt_o} !== {1'b1, 32'h100, 2'b00}) begin
      errors++; $display("FAIL single_fwd: req=%b addr=%h gnt=%b required 1/100/00", cache_req_o, cache_addr_o, req_gnt_o);
    end
    cache_gnt_i = 1;
    #1;
    checks++;
    if (req_gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b required 01", req_gnt_o); end
    step();
    cache_gnt_i = 0; req_req_i = 0;
    cache_rvalid_i = 1; cache_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({cache_req_o, req_rvalid_o, req_rdata_o} !== {1'b0, 2'b01, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_resp: req=%b rvalid=%b rdata=%h required 0/01/deadbeef", cache_req_o, req_rvalid_o, req_rdata_o);
    end
    step();
    cache_rvalid_i = 0;
    #1;
    checks++;
    if ({req_rvalid_o, req_rdata_o} !== {2'b00, 32'h0}) begin
      errors++; $display("FAIL single_idle_after: rvalid=%b rdata=%h required 00/0", req_rvalid_o, req_rdata_o);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr[4];
    logic [1:0]  exp_gnt[4];
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h10, 32'h20, 32'h10, 32'h20};
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_addr = '{32'h10, 32'h10, 32'h10, 32'h10};
    exp_gnt  = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    req_req_i = 2'b11; req_addr_i = {32'h20, 32'h10};
    step();
    for (int i = 0; i < 4; i++) begin
      cache_gnt_i = 1;
      #1;
      checks++;
      if ({cache_req_o, cache_addr_o, req_gnt_o} !== {1'b1, exp_addr[i], exp_gnt[i]}) begin
        errors++; $display("FAIL contention_%0d: req=%b addr=%h gnt=%b required 1/%h/%b", i, cache_req_o, cache_addr_o, req_gnt_o, exp_addr[i], exp_gnt[i]);
      end
      step();
      cache_gnt_i = 0; cache_rvalid_i = 1;
      step();
      cache_rvalid_i = 0;
      step();
    end
    req_req_i = 0;
    cache_gnt_i = 1;
    step();
    cache_gnt_i = 0; cache_rvalid_i = 1;
    step();
    cache_rvalid_i = 0;
  endtask

  task automatic test_write_then_wait();
    do_reset();
    req_req_i = 2'b10; req_addr_i = {32'h40, 32'h80};
    req_we_i = 2'b10; req_be_i = 8'b0011_1111; req_wdata_i = {32'hCAFE_0000, 32'h1111_1111};
    step();
    checks++;
    if ({cache_req_o, cache_we_o, cache_be_o, cache_wdata_o, cache_addr_o} !== {1'b1, 1'b1, 4'b0011, 32'hCAFE_0000, 32'h40}) begin
      errors++; $display("FAIL write_fwd: req=%b we=%b be=%b wdata=%h addr=%h required 1/1/0011/cafe0000/40", cache_req_o, cache_we_o, cache_be_o, cache_wdata_o, cache_addr_o);
    end
    cache_gnt_i = 1;
    step();
    cache_gnt_i = 0; req_req_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (cache_req_o !== 1'b0) begin errors++; $display("FAIL resp_wait_no_req_%0d: got %b required 0", i, cache_req_o); end
      step();
    end
    cache_rvalid_i = 1;
    step();
    cache_rvalid_i = 0;
    #1;
    checks++;
    if (cache_req_o !== 1'b0) begin errors++; $display("FAIL idle_after_rvalid: got %b required 0", cache_req_o); end
    step();
    checks++;
    if ({cache_req_o, cache_we_o, cache_addr_o} !== {1'b1, 1'b0, 32'h80}) begin
      errors++; $display("FAIL req0_start: req=%b we=%b addr=%h required 1/0/80", cache_req_o, cache_we_o, cache_addr_o);
    end
    cache_gnt_i = 1;
    step();
    cache_gnt_i = 0; req_req_i = 0; cache_rvalid_i = 1;
    step();
    cache_rvalid_i = 0;
  endtask

  task automatic test_grant_stall();
    do_reset();
    req_req_i = 2'b01; req_addr_i[31:0] = 32'h200; req_wdata_i[31:0] = 32'h55;
    req_be_i[3:0] = 4'hF; req_we_i = 2'b01;
    step();
    cache_rvalid_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({cache_req_o, cache_addr_o, cache_wdata_o, cache_be_o, cache_we_o, req_gnt_o, req_rvalid_o} !== {1'b1, 32'h200, 32'h55, 4'hF, 1'b1, 2'b00, 2'b00}) begin
        errors++; $display("FAIL stall_%0d: req=%b addr=%h wdata=%h be=%h we=%b gnt=%b rvalid=%b required 1/200/55/f/1/00/00", i, cache_req_o, cache_addr_o, cache_wdata_o, cache_be_o, cache_we_o, req_gnt_o, req_rvalid_o);
      end
      step();
    end
    cache_rvalid_i = 0; cache_gnt_i = 1;
    #1;
    checks++;
    if ({cache_req_o, cache_addr_o, cache_wdata_o, cache_be_o, req_gnt_o} !== {1'b1, 32'h200, 32'h55, 4'hF, 2'b01}) begin
      errors++; $display("FAIL stall_grant: req=%b addr=%h wdata=%h be=%h gnt=%b required 1/200/55/f/01", cache_req_o, cache_addr_o, cache_wdata_o, cache_be_o, req_gnt_o);
    end
    step();
    cache_gnt_i = 0; req_req_i = 0; cache_rvalid_i = 1;
    step();
    cache_rvalid_i = 0;
  endtask

  task automatic test_error();
    do_reset();
    req_req_i = 2'b10; req_addr_i[63:32] = 32'h300;
    step();
    cache_gnt_i = 1;
    step();
    cache_gnt_i = 0; req_req_i = 0; cache_error_i = 1;
    #1;
    checks++;
    if (req_error_o !== 2'b00) begin errors++; $display("FAIL error_unqualified: got %b required 00", req_error_o); end
    step();
    cache_rvalid_i = 1;
    #1;
    checks++;
    if ({req_error_o, req_rvalid_o} !== {2'b10, 2'b10}) begin
      errors++; $display("FAIL error_resp: err=%b rvalid=%b required 10/10", req_error_o, req_rvalid_o);
    end
    step();
    checks++;
    if ({req_error_o, req_rvalid_o} !== 4'b0) begin
      errors++; $display("FAIL error_one_cycle: err=%b rvalid=%b required 00/00", req_error_o, req_rvalid_o);
    end
    cache_rvalid_i = 0; cache_error_i = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_req_i = 2'b01; req_addr_i[31:0] = 32'h500;
    step();
    cache_gnt_i = 1;
    step();
    cache_gnt_i = 0; req_req_i = 0; reset = 1;
    step();
    reset = 0; cache_rvalid_i = 1; cache_rdata_i = 32'h1111_2222;
    #1;
    checks++;
    if ({req_rvalid_o, req_rdata_o, cache_req_o} !== {2'b00, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_mid_stray: rvalid=%b rdata=%h req=%b required 00/0/0", req_rvalid_o, req_rdata_o, cache_req_o);
    end
    step();
    cache_rvalid_i = 0; req_req_i = 2'b01;
    #1;
    checks++;
    if ({req_rvalid_o, cache_req_o} !== 3'b0) begin
      errors++; $display("FAIL reset_mid_idle: rvalid=%b req=%b required 00/0", req_rvalid_o, cache_req_o);
    end
    step();
    checks++;
    if ({cache_req_o, cache_addr_o} !== {1'b1, 32'h500}) begin
      errors++; $display("FAIL reset_mid_rearb: req=%b addr=%h required 1/500", cache_req_o, cache_addr_o);
    end
    req_req_i = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_wait();
    test_grant_stall();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
